// File: rtl/esm_pkg.sv
// ---------------------------------------------------------------------------
// esm_pkg
// Shared definitions for the ESM issue window:
//   - RV32 register-field positions and width
//   - field-extract helper functions
//   - the window entry record (esm_entry_t)
// Imported by esm_issue_window and esm_age_picker.
// ---------------------------------------------------------------------------
package esm_pkg;

    localparam int ESM_INSTR_W = 32;
    localparam int REG_FIELD_W = 5;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;

    // One window slot. 'issued' entries stay in the window until they
    // reach the head and retire.
    typedef struct packed {
        logic [ESM_INSTR_W-1:0] instr;
        logic                   alusrc;
        logic                   regwr;
        logic                   issued;
        logic                   valid;
    } esm_entry_t;

    function automatic logic [REG_FIELD_W-1:0] get_rd(input logic [ESM_INSTR_W-1:0] instr);
        return instr[RD_LSB +: REG_FIELD_W];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] get_rs1(input logic [ESM_INSTR_W-1:0] instr);
        return instr[RS1_LSB +: REG_FIELD_W];
    endfunction

    function automatic logic [REG_FIELD_W-1:0] get_rs2(input logic [ESM_INSTR_W-1:0] instr);
        return instr[RS2_LSB +: REG_FIELD_W];
    endfunction

endpackage

// File: rtl/esm_age_picker.sv
// ---------------------------------------------------------------------------
// esm_age_picker
// Rotating priority encoder: returns the ready slot closest to 'head' in
// circular order, i.e. the oldest ready entry of the window.
// Ports:
//   ready  in  BS     per-slot ready flags
//   head   in  IDX_W  slot of the oldest entry
//   found  out 1      at least one slot is ready
//   idx    out IDX_W  oldest ready slot (head when nothing is ready)
// ---------------------------------------------------------------------------
module esm_age_picker
    import esm_pkg::*;
#(
    parameter  int BS    = 16,
    localparam int IDX_W = $clog2(BS)
) (
    input  logic [BS-1:0]    ready,
    input  logic [IDX_W-1:0] head,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] slot;

    // Scan from youngest to oldest so the last hit, which wins, is the
    // oldest ready slot. The slot index wraps naturally at IDX_W bits.
    always_comb begin
        found = 1'b0;
        idx   = head;
        slot  = head;
        for (int k = BS - 1; k >= 0; k--) begin
            slot = head + IDX_W'(k);
            if (ready[slot]) begin
                found = 1'b1;
                idx   = slot;
            end
        end
    end

endmodule

// File: rtl/esm_issue_window.sv
// ---------------------------------------------------------------------------
// esm_issue_window
// BS-deep circular instruction window with a register scoreboard. Each cycle
// the oldest hazard-free entry is issued into a registered output stage
// (out-of-order pick). Issued entries retire from the head one per cycle.
// Ports:
//   clk, rst              clock, synchronous active-low reset
//   in_valid/in_ready     fetch-side handshake; in_ready = window not full
//   in_instr              instruction word (rd[11:7] rs1[19:15] rs2[24:20])
//   in_alusrc             1: rs2 is not a source (immediate operand)
//   in_regwr              1: instruction writes rd
//   out_valid/out_ready   execute-side handshake (out_valid registered)
//   out_instr, out_index  issued instruction and its window slot
//   wb_valid, wb_rd       writeback: clears busy bit of wb_rd (x0 ignored)
//   count                 occupied window entries
// Configuration macro:
//   ESM_WB_BYPASS_EN  writeback clears also mask the busy vector used for
//                     readiness in the same cycle.
// INSTR_W must equal esm_pkg::ESM_INSTR_W; REGNUM must cover the 5-bit
// register fields.
// ---------------------------------------------------------------------------
module esm_issue_window
    import esm_pkg::*;
#(
    parameter  int INSTR_W = ESM_INSTR_W,
    parameter  int REGNUM  = 32,
    parameter  int BS      = 16,
    localparam int IDX_W   = $clog2(BS),
    localparam int REG_W   = $clog2(REGNUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               in_alusrc,
    input  logic               in_regwr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [IDX_W-1:0]   out_index,
    input  logic               wb_valid,
    input  logic [REG_W-1:0]   wb_rd,
    output logic [IDX_W:0]     count
);

    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(BS);

    esm_entry_t             win [BS];
    logic [IDX_W-1:0]       head;
    logic [IDX_W-1:0]       tail;
    logic [REGNUM-1:0]      busy;
    logic [REGNUM-1:0]      busy_eff;
    logic [REGNUM-1:0]      wb_clr;
    logic [REGNUM-1:0]      issue_set;

    logic [REG_FIELD_W-1:0] rd_f  [BS];
    logic [REG_FIELD_W-1:0] rs1_f [BS];
    logic [REG_FIELD_W-1:0] rs2_f [BS];
    logic [IDX_W-1:0]       age   [BS];
    logic [BS-1:0]          ready;

    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;
    logic [REG_FIELD_W-1:0] pick_rd;
    esm_entry_t             new_entry;

    logic                   do_enq;
    logic                   can_issue;
    logic                   do_issue;
    logic                   do_retire;

    assign in_ready  = (count != FULL_CNT);
    assign do_enq    = in_valid && in_ready;
    assign can_issue = !out_valid || out_ready;
    assign do_issue  = can_issue && pick_found;
    assign do_retire = win[head].valid && win[head].issued;

    // Writeback clear mask; x0 is never tracked.
    always_comb begin
        wb_clr = '0;
        if (wb_valid && (wb_rd != '0)) begin
            wb_clr[wb_rd] = 1'b1;
        end
    end

`ifdef ESM_WB_BYPASS_EN
    assign busy_eff = busy & ~wb_clr;
`else
    assign busy_eff = busy;
`endif

    // Per-slot decoded fields and age relative to head (0 = oldest).
    always_comb begin
        for (int i = 0; i < BS; i++) begin
            rd_f[i]  = get_rd(win[i].instr);
            rs1_f[i] = get_rs1(win[i].instr);
            rs2_f[i] = get_rs2(win[i].instr);
            age[i]   = IDX_W'(i) - head;
        end
    end

    // Readiness: sources not busy, and no RAW/WAR/WAW conflict with any
    // older entry that has not issued yet. Issued older entries are covered
    // by the scoreboard, so only unissued ones are compared here.
    always_comb begin
        ready = '0;
        for (int i = 0; i < BS; i++) begin
            logic rdy;
            rdy = win[i].valid && !win[i].issued;
            if ((rs1_f[i] != '0) && busy_eff[rs1_f[i]]) begin
                rdy = 1'b0;
            end
            if (!win[i].alusrc && (rs2_f[i] != '0) && busy_eff[rs2_f[i]]) begin
                rdy = 1'b0;
            end
            for (int j = 0; j < BS; j++) begin
                if ((j != i) && win[j].valid && !win[j].issued && (age[j] < age[i])) begin
                    if (win[j].regwr && (rd_f[j] != '0) &&
                        ((rd_f[j] == rs1_f[i]) || (!win[i].alusrc && (rd_f[j] == rs2_f[i])))) begin
                        rdy = 1'b0;
                    end
                    if (win[i].regwr && (rd_f[i] != '0)) begin
                        if ((rs1_f[j] == rd_f[i]) || (!win[j].alusrc && (rs2_f[j] == rd_f[i]))) begin
                            rdy = 1'b0;
                        end
                        if (win[j].regwr && (rd_f[j] == rd_f[i])) begin
                            rdy = 1'b0;
                        end
                    end
                end
            end
            ready[i] = rdy;
        end
    end

    esm_age_picker #(
        .BS    (BS)
    ) u_picker (
        .ready (ready),
        .head  (head),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign pick_rd = get_rd(win[pick_idx].instr);

    // Busy bit to set for the instruction being issued this cycle.
    always_comb begin
        issue_set = '0;
        if (do_issue && win[pick_idx].regwr && (pick_rd != '0)) begin
            issue_set[pick_rd] = 1'b1;
        end
    end

    always_comb begin
        new_entry        = '0;
        new_entry.instr  = in_instr;
        new_entry.alusrc = in_alusrc;
        new_entry.regwr  = in_regwr;
        new_entry.issued = 1'b0;
        new_entry.valid  = 1'b1;
    end

    // Window, pointers, scoreboard and output stage. The enqueue slot (tail)
    // is always free, the picked slot is unissued and the retiring head is
    // issued, so the three writes never target the same field of one slot.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BS; i++) begin
                win[i] <= '0;
            end
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            busy      <= '0;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_index <= '0;
        end else begin
            if (do_enq) begin
                win[tail] <= new_entry;
                tail      <= tail + 1'b1;
            end
            if (do_issue) begin
                win[pick_idx].issued <= 1'b1;
            end
            if (do_retire) begin
                win[head].valid  <= 1'b0;
                win[head].issued <= 1'b0;
                head             <= head + 1'b1;
            end
            case ({do_enq, do_retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set wins over a same-cycle writeback clear.
            busy <= (busy & ~wb_clr) | issue_set;
            if (can_issue) begin
                out_valid <= pick_found;
                if (pick_found) begin
                    out_instr <= win[pick_idx].instr;
                    out_index <= pick_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_esm_issue_window.sv
// ---------------------------------------------------------------------------
// tb_esm_issue_window
// Directed bench for esm_issue_window (default parameters). Expected values
// are hand-derived cycle by cycle; ESM_WB_BYPASS_EN shifts the dependent
// issue after a writeback one cycle earlier.
// ---------------------------------------------------------------------------
module tb_esm_issue_window;

`ifdef ESM_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        in_alusrc;
    logic        in_regwr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [3:0]  out_index;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    esm_issue_window dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_alusrc (in_alusrc),
        .in_regwr  (in_regwr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_index (out_index),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input int rd, input int rs1, input int rs2);
        return {7'h00, rs2[4:0], rs1[4:0], 3'b000, rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] i_type(input int rd, input int rs1, input int imm);
        return {imm[11:0], rs1[4:0], 3'b000, rd[4:0], 7'h13};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic alusrc,
                                 input logic regwr);
        in_valid  = v;
        in_instr  = instr;
        in_alusrc = alusrc;
        in_regwr  = regwr;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rst      = 1'b0;
        wb_valid = 1'b0;
        wb_rd    = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
    endtask

    initial begin
        out_ready = 1'b1;
        doReset();
        $display("[TB] reset state");
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_out_index", 64'(out_index), 64'd0);

        // Single ADDI x1: enqueue edge, then issue edge.
        $display("[TB] single ADDI x1");
        applyStimulus(1'b1, i_type(1, 0, 5), 1'b1, 1'b1);
        step();
        checkOutput("t1_count_enq", 64'(count), 64'd1);
        checkOutput("t1_no_early_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        step();
        checkOutput("t1_out_valid", 64'(out_valid), 64'd1);
        checkOutput("t1_out_index", 64'(out_index), 64'd0);
        checkOutput("t1_out_instr", 64'(out_instr), 64'(i_type(1, 0, 5)));
        checkOutput("t1_busy", 64'(dut.busy), 64'h2);
        step();
        checkOutput("t1_retired_count", 64'(count), 64'd0);
        checkOutput("t1_drained_valid", 64'(out_valid), 64'd0);

        // ADD x3,x1,x2 blocked on busy x1; ADDI x5 overtakes it.
        $display("[TB] out-of-order past busy source");
        applyStimulus(1'b1, r_type(3, 1, 2), 1'b0, 1'b1);
        step();
        checkOutput("t2_count1", 64'(count), 64'd1);
        applyStimulus(1'b1, i_type(5, 0, 7), 1'b1, 1'b1);
        step();
        checkOutput("t2_add_blocked", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        step();
        checkOutput("t2_x5_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_x5_index", 64'(out_index), 64'd2);
        checkOutput("t2_x5_instr", 64'(out_instr), 64'(i_type(5, 0, 7)));
        checkOutput("t2_count2", 64'(count), 64'd2);
        checkOutput("t2_busy", 64'(dut.busy), 64'h22);
        wb_valid = 1'b1;
        wb_rd    = 5'd1;
        step();
        wb_valid = 1'b0;
        checkOutput("t2_busy_after_wb", 64'(dut.busy), BYP ? 64'h28 : 64'h20);
        if (!BYP) begin
            checkOutput("t2_wb_not_visible", 64'(out_valid), 64'd0);
            step();
        end
        checkOutput("t2_add_valid", 64'(out_valid), 64'd1);
        checkOutput("t2_add_index", 64'(out_index), 64'd1);
        checkOutput("t2_add_instr", 64'(out_instr), 64'(r_type(3, 1, 2)));

        // WAR / WAW: I1 reads x4 (blocked on x8) and writes x6; I2 writes x4,
        // I3 writes x6. Both younger ones wait for I1.
        $display("[TB] WAR and WAW holds");
        doReset();
        applyStimulus(1'b1, i_type(8, 0, 1), 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, r_type(6, 4, 8), 1'b0, 1'b1);
        step();
        checkOutput("t3_i0_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_i0_index", 64'(out_index), 64'd0);
        applyStimulus(1'b1, i_type(4, 0, 2), 1'b1, 1'b1);
        step();
        checkOutput("t3_count_e3", 64'(count), 64'd2);
        checkOutput("t3_i1_blocked", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, i_type(6, 0, 3), 1'b1, 1'b1);
        step();
        checkOutput("t3_war_hold", 64'(out_valid), 64'd0);
        checkOutput("t3_count_e4", 64'(count), 64'd3);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        wb_valid = 1'b1;
        wb_rd    = 5'd8;
        step();
        wb_valid = 1'b0;
        if (!BYP) begin
            checkOutput("t3_waw_hold", 64'(out_valid), 64'd0);
            step();
        end
        checkOutput("t3_i1_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_i1_index", 64'(out_index), 64'd1);
        step();
        checkOutput("t3_i2_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_i2_index", 64'(out_index), 64'd2);
        step();
        checkOutput("t3_i3_valid", 64'(out_valid), 64'd1);
        checkOutput("t3_i3_index", 64'(out_index), 64'd3);
        step();
        checkOutput("t3_drained", 64'(out_valid), 64'd0);

        // Fill with execute stalled. Slot 0 issues into the stalled output
        // and retires, so 17 enqueues reach a count of 16.
        $display("[TB] fill with execute stalled");
        doReset();
        out_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, i_type(0, 0, k), 1'b1, 1'b1);
            step();
            if (k == 8) begin
                checkOutput("t4_stall_instr_mid", 64'(out_instr), 64'(i_type(0, 0, 0)));
            end
        end
        checkOutput("t4_count_full", 64'(count), 64'd16);
        checkOutput("t4_in_ready_low", 64'(in_ready), 64'd0);
        applyStimulus(1'b1, i_type(0, 0, 99), 1'b1, 1'b1);
        step();
        checkOutput("t4_count_hold", 64'(count), 64'd16);
        checkOutput("t4_in_ready_hold", 64'(in_ready), 64'd0);
        checkOutput("t4_stall_valid", 64'(out_valid), 64'd1);
        checkOutput("t4_stall_instr", 64'(out_instr), 64'(i_type(0, 0, 0)));
        checkOutput("t4_stall_index", 64'(out_index), 64'd0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        out_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            checkOutput("t4_drain_instr", 64'(out_instr), 64'(i_type(0, 0, k)));
            checkOutput("t4_drain_index", 64'(out_index), 64'(k % 16));
        end
        step();
        checkOutput("t4_dropped_absent", 64'(out_valid), 64'd0);
        checkOutput("t4_count_empty", 64'(count), 64'd0);

        // Streaming with wrap-around of both pointers.
        $display("[TB] 40-instruction stream");
        doReset();
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, i_type(0, 0, 100 + k), 1'b1, 1'b1);
            step();
            if (k == 0) begin
                checkOutput("t5_first_valid", 64'(out_valid), 64'd0);
                checkOutput("t5_first_count", 64'(count), 64'd1);
            end else begin
                checkOutput("t5_instr", 64'(out_instr), 64'(i_type(0, 0, 100 + k - 1)));
                checkOutput("t5_index", 64'(out_index), 64'((k - 1) % 16));
                checkOutput("t5_count", 64'(count), 64'd2);
            end
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        step();
        checkOutput("t5_last_instr", 64'(out_instr), 64'(i_type(0, 0, 139)));
        checkOutput("t5_last_index", 64'(out_index), 64'd7);

        // Reset while the output register holds a valid instruction.
        $display("[TB] reset mid-stream");
        doReset();
        applyStimulus(1'b1, i_type(7, 0, 1), 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, i_type(9, 0, 2), 1'b1, 1'b1);
        step();
        checkOutput("t6_pre_valid", 64'(out_valid), 64'd1);
        checkOutput("t6_pre_busy", 64'(dut.busy), 64'h80);
        checkOutput("t6_pre_count", 64'(count), 64'd2);
        rst = 1'b0;
        step();
        checkOutput("t6_out_valid", 64'(out_valid), 64'd0);
        checkOutput("t6_count", 64'(count), 64'd0);
        checkOutput("t6_busy", 64'(dut.busy), 64'h0);
        checkOutput("t6_in_ready", 64'(in_ready), 64'd1);
        checkOutput("t6_out_instr", 64'(out_instr), 64'd0);
        checkOutput("t6_out_index", 64'(out_index), 64'd0);
        rst = 1'b1;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        checkOutput("t6_discarded", 64'(out_valid), 64'd0);
        checkOutput("t6_count_after", 64'(count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
